// File: rtl/alarm_qsys_led_sequencer_if.sv
// rtl/alarm_qsys_led_sequencer_if.sv - Avalon-MM register bus bundle for the LED sequencer
// Signals: address[1:0], chipselect, write_n (active low), writedata[31:0],
//          readdata[31:0] (combinational from the slave).
// Modports: master drives the request side, slave returns readdata.
interface alarm_qsys_led_sequencer_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );
endinterface

// File: rtl/alarm_qsys_led_sequencer.sv
// rtl/alarm_qsys_led_sequencer.sv - CPU-configured LED pattern sequencer with alarm flash override
// Ports:
//   clk           system clock
//   reset_n       asynchronous active-low reset
//   bus           Avalon-MM slave: PATTERN(0), CTRL(1), PERIOD(2), STATUS(3, read-only)
//   alarm_active  high while the alarm rings
//   out_port      registered drive for the 8 board LEDs
module alarm_qsys_led_sequencer #(
    parameter int                   DIV_WIDTH      = 24,
    parameter logic [DIV_WIDTH-1:0] DEFAULT_PERIOD = 24'd12_499_999
) (
    input  logic                          clk,
    input  logic                          reset_n,
    alarm_qsys_led_sequencer_if.slave     bus,
    input  logic                          alarm_active,
    output logic [7:0]                    out_port
);

    localparam logic [1:0] MODE_STATIC = 2'd0;
    localparam logic [1:0] MODE_BLINK  = 2'd1;
    localparam logic [1:0] MODE_LEFT   = 2'd2;
    localparam logic [1:0] MODE_RIGHT  = 2'd3;

    logic [7:0]           pattern;
    logic [2:0]           ctrl;
    logic [DIV_WIDTH-1:0] period;
    logic [DIV_WIDTH-1:0] cnt;
    logic                 phase;
    logic [7:0]           frame;
    logic                 alarm_q;

    logic                 wr;
    logic                 step;
    logic                 alarm_rise;
    logic                 restart;
    logic                 override;
    logic [7:0]           restart_frame;
    logic [7:0]           out_sel;

    assign wr         = bus.chipselect && !bus.write_n;
    assign step       = (cnt == period);
    // alarm_q holds last edge's sample, so the rise is acted on at the
    // first edge that sees alarm_active high.
    assign alarm_rise = alarm_active && !alarm_q;
    assign restart    = (wr && (bus.address != 2'd3)) || alarm_rise;
    assign override   = alarm_active && ctrl[2];

    // A PATTERN write restarts the chase from the value being written,
    // not the one it replaces.
    assign restart_frame = (wr && (bus.address == 2'd0)) ? bus.writedata[7:0] : pattern;

    always_comb begin
        out_sel = frame;
        if (override) begin
            out_sel = phase ? 8'hFF : 8'h00;
        end else begin
            case (ctrl[1:0])
                MODE_STATIC: out_sel = pattern;
                MODE_BLINK:  out_sel = phase ? pattern : 8'h00;
                default:     out_sel = frame;
            endcase
        end
    end

    always_comb begin
        bus.readdata = 32'd0;
        case (bus.address)
            2'd0: bus.readdata = {24'd0, pattern};
            2'd1: bus.readdata = {29'd0, ctrl};
            2'd2: bus.readdata = 32'(period);
            2'd3: bus.readdata = {22'd0, phase, override, out_port};
            default: bus.readdata = 32'd0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pattern  <= 8'd0;
            ctrl     <= 3'b100;
            period   <= DEFAULT_PERIOD;
            cnt      <= '0;
            phase    <= 1'b1;
            frame    <= 8'd0;
            alarm_q  <= 1'b0;
            out_port <= 8'd0;
        end else begin
            alarm_q  <= alarm_active;
            out_port <= out_sel;

            if (wr) begin
                case (bus.address)
                    2'd0: pattern <= bus.writedata[7:0];
                    2'd1: ctrl    <= bus.writedata[2:0];
                    2'd2: period  <= bus.writedata[DIV_WIDTH-1:0];
                    default: ;
                endcase
            end

            // Restart has priority: a step landing on the same edge is dropped.
            if (restart) begin
                cnt   <= '0;
                phase <= 1'b1;
                frame <= restart_frame;
            end else if (step) begin
                cnt   <= '0;
                phase <= ~phase;
                case (ctrl[1:0])
                    MODE_LEFT:  frame <= {frame[6:0], frame[7]};
                    MODE_RIGHT: frame <= {frame[0], frame[7:1]};
                    default:    frame <= frame;
                endcase
            end else begin
                cnt <= cnt + DIV_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_alarm_qsys_led_sequencer.sv
// tb/tb_alarm_qsys_led_sequencer.sv - self-checking bench for alarm_qsys_led_sequencer
module tb_alarm_qsys_led_sequencer;

    logic       clk;
    logic       reset_n;
    logic       alarm_active;
    logic [7:0] out_port;

    alarm_qsys_led_sequencer_if bus ();

    alarm_qsys_led_sequencer dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .bus          (bus),
        .alarm_active (alarm_active),
        .out_port     (out_port)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: time since the last restart determines everything.
    int         m_t;
    logic [7:0] m_pat;
    logic [7:0] m_base;
    logic [2:0] m_ctrl;
    logic [23:0] m_per;
    logic [7:0] m_out;
    logic       m_alarm_prev;

    function automatic int m_steps();
        return m_t / (int'(m_per) + 1);
    endfunction

    function automatic logic m_phase();
        return (m_steps() % 2) == 0;
    endfunction

    function automatic logic [7:0] m_frame();
        int k;
        logic [15:0] dd;
        logic [15:0] sh;
        k  = m_steps() % 8;
        dd = {m_base, m_base};
        if (m_ctrl[1:0] == 2'd2) begin
            sh = dd << k;
            return sh[15:8];
        end else if (m_ctrl[1:0] == 2'd3) begin
            sh = dd >> k;
            return sh[7:0];
        end
        return m_base;
    endfunction

    function automatic logic [7:0] m_select(input logic al);
        if (al && m_ctrl[2]) return m_phase() ? 8'hFF : 8'h00;
        case (m_ctrl[1:0])
            2'd0: return m_pat;
            2'd1: return m_phase() ? m_pat : 8'h00;
            default: return m_frame();
        endcase
    endfunction

    function automatic logic [31:0] m_read(input logic [1:0] a, input logic al);
        case (a)
            2'd0: return {24'd0, m_pat};
            2'd1: return {29'd0, m_ctrl};
            2'd2: return {8'd0, m_per};
            default: return {22'd0, m_phase(), al && m_ctrl[2], m_out};
        endcase
    endfunction

    task automatic m_reset();
        m_t = 0; m_pat = 8'd0; m_base = 8'd0; m_ctrl = 3'b100;
        m_per = 24'd12_499_999; m_out = 8'd0; m_alarm_prev = 1'b0;
    endtask

    // One clock: drive inputs, check combinational readdata, advance model and DUT, check out_port.
    task automatic cycle(input logic cs, input logic wn, input logic [1:0] a,
                         input logic [31:0] d, input logic al);
        logic [7:0]  n_out;
        logic [31:0] exp_rd;
        logic        restart;
        bus.chipselect = cs; bus.write_n = wn; bus.address = a; bus.writedata = d;
        alarm_active = al;
        #1;
        exp_rd = m_read(a, al);
        checks++;
        if (bus.readdata !== exp_rd) begin
            errors++;
            $display("FAIL readdata addr=%0d t=%0t got=%h exp=%h", a, $time, bus.readdata, exp_rd);
        end
        n_out   = m_select(al);
        restart = (cs && !wn && a != 2'd3) || (al && !m_alarm_prev);
        if (cs && !wn) begin
            case (a)
                2'd0: m_pat  = d[7:0];
                2'd1: m_ctrl = d[2:0];
                2'd2: m_per  = d[23:0];
                default: ;
            endcase
        end
        if (restart) begin
            m_t = 0;
            m_base = m_pat;
        end else begin
            m_t++;
        end
        m_alarm_prev = al;
        m_out = n_out;
        @(posedge clk);
        #1;
        checks++;
        if (out_port !== m_out) begin
            errors++;
            $display("FAIL out_port t=%0t got=%h exp=%h", $time, out_port, m_out);
        end
    endtask

    task automatic wr_reg(input logic [1:0] a, input logic [31:0] d, input logic al);
        cycle(1'b1, 1'b0, a, d, al);
    endtask

    task automatic idle(input int n, input logic [1:0] a, input logic al);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b1, a, 32'd0, al);
    endtask

    task automatic test_reset();
        logic [31:0] exp_r [3];
        exp_r[0] = 32'd0; exp_r[1] = 32'd4; exp_r[2] = 32'd12_499_999;
        wr_reg(2, 32'd0, 1'b0);
        wr_reg(0, 32'h81, 1'b0);
        wr_reg(1, 32'd2, 1'b0);
        idle(5, 0, 1'b0);
        reset_n = 1'b0;
        #1;
        m_reset();
        checks++;
        if (out_port !== 8'h00) begin
            errors++;
            $display("FAIL reset_out got=%h exp=00", out_port);
        end
        bus.chipselect = 1'b1; bus.write_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.address = 2'(i);
            #1;
            checks++;
            if (bus.readdata !== exp_r[i]) begin
                errors++;
                $display("FAIL reset_reg%0d got=%h exp=%h", i, bus.readdata, exp_r[i]);
            end
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_blink();
        logic [7:0] exp_seq [8];
        for (int i = 0; i < 8; i++) exp_seq[i] = (i < 4) ? 8'hA5 : 8'h00;
        wr_reg(2, 32'd3, 1'b0);
        wr_reg(0, 32'hA5, 1'b0);
        wr_reg(1, 32'd1, 1'b0);
        for (int i = 0; i < 8; i++) begin
            idle(1, 3, 1'b0);
            checks++;
            if (out_port !== exp_seq[i]) begin
                errors++;
                $display("FAIL blink[%0d] got=%h exp=%h", i, out_port, exp_seq[i]);
            end
        end
        idle(8, 3, 1'b0);
    endtask

    task automatic test_chase_left();
        logic [7:0] exp_seq [9];
        exp_seq = '{8'h81, 8'h03, 8'h06, 8'h0C, 8'h18, 8'h30, 8'h60, 8'hC0, 8'h81};
        wr_reg(2, 32'd0, 1'b0);
        wr_reg(0, 32'h81, 1'b0);
        wr_reg(1, 32'd2, 1'b0);
        for (int i = 0; i < 9; i++) begin
            idle(1, 0, 1'b0);
            checks++;
            if (out_port !== exp_seq[i]) begin
                errors++;
                $display("FAIL chase_left[%0d] got=%h exp=%h", i, out_port, exp_seq[i]);
            end
        end
    endtask

    task automatic test_collision();
        int guard;
        wr_reg(2, 32'd1, 1'b0);
        wr_reg(1, 32'd3, 1'b0);
        wr_reg(0, 32'h01, 1'b0);
        idle(3, 0, 1'b0);
        guard = 0;
        // Step fires on the coming edge when the counter sits at PERIOD.
        while ((m_t % 2) != 1 && guard < 4) begin
            idle(1, 0, 1'b0);
            guard++;
        end
        wr_reg(0, 32'h10, 1'b0);
        idle(1, 0, 1'b0);
        checks++;
        if (out_port !== 8'h10) begin
            errors++;
            $display("FAIL collision_first got=%h exp=10", out_port);
        end
        idle(2, 0, 1'b0);
        checks++;
        if (out_port !== 8'h08) begin
            errors++;
            $display("FAIL collision_next got=%h exp=08", out_port);
        end
    endtask

    task automatic test_override();
        wr_reg(2, 32'd3, 1'b0);
        wr_reg(0, 32'h81, 1'b0);
        wr_reg(1, 32'b110, 1'b0);
        idle(6, 0, 1'b0);
        idle(2, 3, 1'b1);
        checks++;
        if (out_port !== 8'hFF) begin
            errors++;
            $display("FAIL override_ff got=%h exp=FF", out_port);
        end
        checks++;
        if (bus.readdata[8] !== 1'b1) begin
            errors++;
            $display("FAIL override_status got=%b exp=1", bus.readdata[8]);
        end
        idle(12, 3, 1'b1);
        idle(10, 3, 1'b0);
        wr_reg(1, 32'b010, 1'b0);
        idle(3, 3, 1'b0);
        idle(10, 3, 1'b1);
        checks++;
        if (bus.readdata[8] !== 1'b0) begin
            errors++;
            $display("FAIL no_override_status got=%b exp=0", bus.readdata[8]);
        end
        idle(3, 3, 1'b0);
    endtask

    task automatic test_period_shrink();
        logic exp_ph [3];
        exp_ph = '{1'b1, 1'b1, 1'b0};
        wr_reg(1, 32'd0, 1'b0);
        wr_reg(2, 32'd1000, 1'b0);
        idle(500, 3, 1'b0);
        wr_reg(2, 32'd2, 1'b0);
        for (int i = 0; i < 3; i++) begin
            idle(1, 3, 1'b0);
            checks++;
            if (bus.readdata[9] !== exp_ph[i]) begin
                errors++;
                $display("FAIL shrink_phase[%0d] got=%b exp=%b", i, bus.readdata[9], exp_ph[i]);
            end
        end
    endtask

    task automatic test_random();
        logic al;
        logic [1:0] a;
        logic [31:0] d;
        al = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 19) == 0) al = ~al;
            a = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 9) == 0) begin
                d = $urandom();
                if (a == 2'd2) d = 32'($urandom_range(0, 5));
                wr_reg(a, d, al);
            end else begin
                idle(1, a, al);
            end
        end
        idle(2, 0, 1'b0);
    endtask

    initial begin
        reset_n = 1'b0;
        alarm_active = 1'b0;
        bus.chipselect = 1'b0; bus.write_n = 1'b1; bus.address = 2'd0; bus.writedata = 32'd0;
        m_reset();
        #12;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (out_port !== 8'h00) begin
            errors++;
            $display("FAIL initial_out got=%h exp=00", out_port);
        end
        test_reset();
        test_blink();
        test_chase_left();
        test_collision();
        test_override();
        test_period_shrink();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
